// File: rtl/determ_add_accum_pkg.sv
// Shared constants and width helpers for the deterministic-bitstream arithmetic blocks.
package determ_add_accum_pkg;

  typedef enum logic {
    MODE_SUM  = 1'b0,
    MODE_MEAN = 1'b1
  } mode_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    longint unsigned p;
    r = 0;
    p = 1;
    while (p < longint'(v)) begin
      p = p << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Signed width holding one per-sample value in [-num_in, num_in].
  function automatic int unsigned samp_w(input int unsigned num_in);
    return clog2(num_in + 1) + 1;
  endfunction

  // Accumulator width: a full window can never wrap.
  function automatic int unsigned acc_w(input int unsigned num_in, input int unsigned wlog2);
    return samp_w(num_in) + wlog2;
  endfunction

endpackage

// File: rtl/determ_add_accum_popcount.sv
// Converts one bit per stream into the signed per-sample sum 2*popcount(a) - NUM_IN.
module determ_add_accum_popcount
  import determ_add_accum_pkg::*;
#(
  parameter int unsigned NUM_IN = 4
) (
  input  logic [NUM_IN-1:0]                a,
  output logic signed [samp_w(NUM_IN)-1:0] s
);

  localparam int unsigned S_W = samp_w(NUM_IN);

  logic [S_W-1:0] ones;

  // Count the +1 streams.
  always_comb begin
    ones = '0;
    for (int i = 0; i < int'(NUM_IN); i++) begin
      ones = ones + S_W'(a[i]);
    end
  end

  // Modular arithmetic is exact here since the final value always fits S_W bits.
  assign s = signed'((ones << 1) - S_W'(NUM_IN));

endmodule

// File: rtl/determ_add_accum.sv
// Windowed adder/accumulator for deterministic bitstreams with a saturating fixed-point output.
module determ_add_accum
  import determ_add_accum_pkg::*;
#(
  parameter int unsigned NUM_IN      = 4,
  parameter int unsigned BIT_WIDTH   = 16,
  parameter int unsigned INT_WIDTH   = 4,
  parameter int unsigned WINDOW_LOG2 = 4
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [NUM_IN-1:0]    a,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 mode,
  input  logic                 clear,
  output logic [BIT_WIDTH-1:0] y,
  output logic                 sat,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int unsigned FRAC   = BIT_WIDTH - INT_WIDTH;
  localparam int unsigned S_W    = samp_w(NUM_IN);
  localparam int unsigned ACC_W  = acc_w(NUM_IN, WINDOW_LOG2);
  localparam int unsigned WIDE_W = ACC_W + BIT_WIDTH;

  logic signed [S_W-1:0]    s;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_next;
  logic [WINDOW_LOG2-1:0]   cnt;
  logic                     last;
  logic                     accept;
  logic                     win_end;
  logic signed [WIDE_W-1:0] wide;
  logic signed [WIDE_W-1:0] scaled;
  logic [BIT_WIDTH-1:0]     y_next;
  logic                     sat_next;

  determ_add_accum_popcount #(
    .NUM_IN(NUM_IN)
  ) u_popcount (
    .a(a),
    .s(s)
  );

  // Only the last sample of a window stalls, and only behind an untaken result.
  assign last     = &cnt;
  assign in_ready = !(last && out_valid && !out_ready);
  assign accept   = in_valid && in_ready;
  assign win_end  = accept && last && !clear;
  assign acc_next = acc + ACC_W'(s);

  // Scale the window sum to Q(INT_WIDTH).(FRAC), optionally average, then clip.
  always_comb begin
    wide     = WIDE_W'(acc_next) <<< FRAC;
    scaled   = (mode_e'(mode) == MODE_MEAN) ? (wide >>> WINDOW_LOG2) : wide;
    y_next   = scaled[BIT_WIDTH-1:0];
    sat_next = 1'b0;
    if (!(&scaled[WIDE_W-1:BIT_WIDTH-1]) && (|scaled[WIDE_W-1:BIT_WIDTH-1])) begin
      sat_next = 1'b1;
      y_next   = scaled[WIDE_W-1] ? {1'b1, {(BIT_WIDTH-1){1'b0}}}
                                  : {1'b0, {(BIT_WIDTH-1){1'b1}}};
    end
  end

  // Window accumulator and sample counter; clear drops any simultaneous sample.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      acc <= last ? '0 : acc_next;
      cnt <= cnt + WINDOW_LOG2'(1);
    end
  end

  // Result register with valid/ready hand-off; a new load overrides the drop.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      out_valid <= 1'b0;
      y         <= '0;
      sat       <= 1'b0;
    end else if (win_end) begin
      out_valid <= 1'b1;
      y         <= y_next;
      sat       <= sat_next;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
